// File: rtl/axi_slave_mem.sv
// AXI4 slave with an internal word-addressed memory.
// Independent write (AW/W/B) and read (AR/R) state machines; FIXED and INCR
// bursts at full bus width, byte strobes, per-beat SLVERR on bad requests.
module axi_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // write address
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic [1:0]              aw_burst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  // write data
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  // write response
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  // read address
  input  logic [ID_WIDTH-1:0]     ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [1:0]              ar_burst_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  // read data
  output logic [ID_WIDTH-1:0]     r_id_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Address of the following beat: INCR steps one bus word, FIXED holds.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + ADDR_WIDTH'(STRB_W) : a;
  endfunction

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  function automatic logic word_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFFS) < ADDR_WIDTH'(MEM_WORDS);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // ---------------- write path state ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic                  aw_ready_q, aw_ready_d;
  logic                  w_ready_q, w_ready_d;
  logic                  b_valid_q, b_valid_d;
  logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
  logic [1:0]            b_resp_q, b_resp_d;

  logic [ADDR_WIDTH-1:0] w_word_c;
  logic [IDX_W-1:0]      w_idx_c;
  logic                  w_beat_ok_c;
  logic                  w_last_beat_c;
  logic                  w_err_nxt_c;
  logic                  mem_we_c;

  assign w_word_c      = w_addr_q >> OFFS;
  assign w_idx_c       = w_word_c[IDX_W-1:0];
  assign w_beat_ok_c   = burst_ok(w_burst_q) && word_ok(w_addr_q);
  assign w_last_beat_c = (w_cnt_q == w_len_q);
  // Error accumulates bad beats and any w_last disagreement with the count
  assign w_err_nxt_c   = w_err_q || !w_beat_ok_c || (w_last_i != w_last_beat_c);

  // Write FSM next-state and registered-output logic
  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_burst_d  = w_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_id_d     = b_id_q;
    b_resp_d   = b_resp_q;
    mem_we_c   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_d = 1'b1;
        if (aw_valid_i && aw_ready_q) begin
          w_state_d  = W_DATA;
          w_addr_d   = aw_addr_i;
          w_len_d    = aw_len_i;
          w_burst_d  = aw_burst_i;
          w_cnt_d    = 8'd0;
          w_err_d    = 1'b0;
          b_id_d     = aw_id_i;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
        end
      end
      W_DATA: begin
        if (w_valid_i && w_ready_q) begin
          mem_we_c = w_beat_ok_c;
          w_err_d  = w_err_nxt_c;
          if (w_last_beat_c) begin
            w_state_d = W_RESP;
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = w_err_nxt_c ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_cnt_d  = w_cnt_q + 8'd1;
            w_addr_d = next_addr(w_addr_q, w_burst_q);
          end
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          w_state_d  = W_IDLE;
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
        end
      end
      default: begin
        w_state_d  = W_IDLE;
        aw_ready_d = 1'b0;
        w_ready_d  = 1'b0;
        b_valid_d  = 1'b0;
      end
    endcase
  end

  // Write FSM state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_burst_q  <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_burst_q  <= w_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_id_q     <= b_id_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // Byte-masked memory write; contents are intentionally not reset
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (w_strb_i[b]) mem_q[w_idx_c][b*8 +: 8] <= w_data_i[b*8 +: 8];
      end
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = b_resp_q;

  // ---------------- read path state ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  ar_ready_q, ar_ready_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  r_last_q, r_last_d;
  logic                  r_valid_q, r_valid_d;

  logic [ADDR_WIDTH-1:0] r_load_addr_c;
  logic [1:0]            r_load_burst_c;
  logic [ADDR_WIDTH-1:0] r_word_c;
  logic [IDX_W-1:0]      r_idx_c;
  logic                  r_load_ok_c;
  logic [DATA_WIDTH-1:0] r_mem_c;

  // Beat being loaded: the AR address when idle, otherwise the tracked address
  assign r_load_addr_c  = (r_state_q == R_IDLE) ? ar_addr_i  : r_addr_q;
  assign r_load_burst_c = (r_state_q == R_IDLE) ? ar_burst_i : r_burst_q;
  assign r_word_c       = r_load_addr_c >> OFFS;
  assign r_idx_c        = r_word_c[IDX_W-1:0];
  assign r_load_ok_c    = burst_ok(r_load_burst_c) && word_ok(r_load_addr_c);
  assign r_mem_c        = mem_q[r_idx_c];

  // Read FSM next-state and registered-output logic
  always_comb begin
    r_state_d  = r_state_q;
    r_addr_d   = r_addr_q;
    r_len_d    = r_len_q;
    r_burst_d  = r_burst_q;
    r_cnt_d    = r_cnt_q;
    ar_ready_d = ar_ready_q;
    r_id_d     = r_id_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    r_valid_d  = r_valid_q;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (ar_valid_i && ar_ready_q) begin
          r_state_d  = R_DATA;
          ar_ready_d = 1'b0;
          r_id_d     = ar_id_i;
          r_len_d    = ar_len_i;
          r_burst_d  = ar_burst_i;
          r_cnt_d    = 8'd0;
          r_addr_d   = next_addr(ar_addr_i, ar_burst_i);
          r_valid_d  = 1'b1;
          r_data_d   = r_load_ok_c ? r_mem_c : '0;
          r_resp_d   = r_load_ok_c ? RESP_OKAY : RESP_SLVERR;
          r_last_d   = (ar_len_i == 8'd0);
        end
      end
      R_DATA: begin
        if (r_ready_i) begin
          if (r_last_q) begin
            r_state_d  = R_IDLE;
            r_valid_d  = 1'b0;
            r_last_d   = 1'b0;
            ar_ready_d = 1'b1;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = next_addr(r_addr_q, r_burst_q);
            r_data_d = r_load_ok_c ? r_mem_c : '0;
            r_resp_d = r_load_ok_c ? RESP_OKAY : RESP_SLVERR;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: begin
        r_state_d  = R_IDLE;
        ar_ready_d = 1'b0;
        r_valid_d  = 1'b0;
        r_last_d   = 1'b0;
      end
    endcase
  end

  // Read FSM state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_burst_q  <= '0;
      r_cnt_q    <= '0;
      ar_ready_q <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
      r_valid_q  <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_addr_q   <= r_addr_d;
      r_len_q    <= r_len_d;
      r_burst_q  <= r_burst_d;
      r_cnt_q    <= r_cnt_d;
      ar_ready_q <= ar_ready_d;
      r_id_q     <= r_id_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
      r_valid_q  <= r_valid_d;
    end
  end

  assign ar_ready_o = ar_ready_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign r_last_o   = r_last_q;
  assign r_valid_o  = r_valid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them on every handshake.
module tb_axi_slave_mem;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned MW = 1024;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk;
  logic rst_ni;
  logic [IW-1:0] aw_id;  logic [AW-1:0] aw_addr; logic [7:0] aw_len; logic [1:0] aw_burst;
  logic aw_valid; logic aw_ready_o;
  logic [DW-1:0] w_data; logic [DW/8-1:0] w_strb; logic w_last; logic w_valid; logic w_ready_o;
  logic [IW-1:0] b_id_o; logic [1:0] b_resp_o; logic b_valid_o; logic b_ready;
  logic [IW-1:0] ar_id;  logic [AW-1:0] ar_addr; logic [7:0] ar_len; logic [1:0] ar_burst;
  logic ar_valid; logic ar_ready_o;
  logic [IW-1:0] r_id_o; logic [DW-1:0] r_data_o; logic [1:0] r_resp_o;
  logic r_last_o; logic r_valid_o; logic r_ready;

  axi_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_WORDS(MW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_burst_i(aw_burst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid),
    .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_burst_i(ar_burst),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  int n_pass;
  int n_chk;

  logic [DW-1:0]   wd   [16];
  logic [DW/8-1:0] ws   [16];
  logic [DW-1:0]   rd_d [16];
  logic [1:0]      rd_r [16];

  logic bp_en;
  logic r_hold;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  // Ready generation: random when backpressure is enabled
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      b_ready = 1'($urandom_range(0, 1));
      r_ready = 1'($urandom_range(0, 1));
    end else begin
      b_ready = 1'b1;
      r_ready = !r_hold;
    end
  end

  // Monitor: compares responses against the scoreboard queues
  r_exp_t mr;
  b_exp_t mb;
  logic   r_pend;
  logic [IW-1:0] h_id; logic [DW-1:0] h_data; logic [1:0] h_resp; logic h_last;
  always @(negedge clk) begin
    if (!rst_ni) begin
      r_pend = 1'b0;
    end else begin
      if (r_pend) begin
        chk("r_stall_hold", 128'({r_valid_o, r_last_o, r_resp_o, r_id_o, r_data_o}),
            128'({1'b1, h_last, h_resp, h_id, h_data}));
        r_pend = 1'b0;
      end
      if (r_valid_o && r_ready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin
          mr = exp_r.pop_front();
          chk("r_beat", 128'({r_id_o, r_resp_o, r_last_o, r_data_o}),
              128'({mr.id, mr.resp, mr.last, mr.data}));
        end
      end else if (r_valid_o) begin
        r_pend = 1'b1;
        h_id = r_id_o; h_data = r_data_o; h_resp = r_resp_o; h_last = r_last_o;
      end
      if (b_valid_o && b_ready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else begin
          mb = exp_b.pop_front();
          chk("b_resp", 128'({b_id_o, b_resp_o}), 128'({mb.id, mb.resp}));
        end
      end
    end
  end

  task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    bit hs = 1'b0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
    for (int t = 0; t < 500 && !hs; t++) begin
      @(negedge clk);
      if (aw_ready_o) hs = 1'b1;
    end
    @(posedge clk); #1;
    aw_valid = 1'b0;
    if (!hs) fail_now("aw_timeout");
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic l);
    bit hs = 1'b0;
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
    for (int t = 0; t < 500 && !hs; t++) begin
      @(negedge clk);
      if (w_ready_o) hs = 1'b1;
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
    if (!hs) fail_now("w_timeout");
  endtask

  task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    bit hs = 1'b0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_valid = 1'b1;
    for (int t = 0; t < 500 && !hs; t++) begin
      @(negedge clk);
      if (ar_ready_o) hs = 1'b1;
    end
    @(posedge clk); #1;
    ar_valid = 1'b0;
    if (!hs) fail_now("ar_timeout");
  endtask

  // Write burst from wd/ws; beat index 'bad' has w_last inverted
  task automatic wr(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input int bad, input logic [1:0] resp);
    exp_b.push_back('{id, resp});
    aw_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++)
      w_send(wd[i], ws[i], (i == int'(len)) != (i == bad));
  endtask

  // Read burst expecting rd_d/rd_r
  task automatic rd(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                    input logic [1:0] burst);
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{id, rd_d[i], rd_r[i], i == int'(len)});
    ar_send(id, addr, len, burst);
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && (exp_b.size() != 0 || exp_r.size() != 0); t++)
      @(posedge clk);
    #1;
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      fail_now("drain_timeout");
      exp_b.delete();
      exp_r.delete();
    end
  endtask

  initial begin
    n_pass = 0; n_chk = 0;
    rst_ni = 1'b0; bp_en = 1'b0; r_hold = 1'b0;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0;
    w_data = '0; w_strb = '0; w_last = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = '1; rd_d[i] = '0; rd_r[i] = OKAY; end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 128'({aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o}), 128'(0));
    chk("rst_data", 128'({b_id_o, b_resp_o, r_id_o, r_resp_o, r_data_o}), 128'(0));
    rst_ni = 1'b1;
    #1 chk("ready_before_edge", 128'({aw_ready_o, ar_ready_o}), 128'(2'b00));
    @(posedge clk); #1;
    chk("ready_after_rst", 128'({aw_ready_o, ar_ready_o}), 128'(2'b11));

    // INCR write then read back
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    wr(4'd3, 32'h40, 8'd3, INCR, -1, OKAY);
    drain();
    rd_d[0] = 64'h11; rd_d[1] = 64'h22; rd_d[2] = 64'h33; rd_d[3] = 64'h44;
    rd(4'd5, 32'h40, 8'd3, INCR);
    drain();

    // FIXED write merging two strobed halves into one word
    wd[0] = 64'hAAAA_AAAA_1111_1111; ws[0] = 8'h0F;
    wd[1] = 64'h2222_2222_BBBB_BBBB; ws[1] = 8'hF0;
    wr(4'd1, 32'h8, 8'd1, FIXED, -1, OKAY);
    drain();
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    rd_d[0] = 64'h2222_2222_1111_1111;
    rd(4'd2, 32'h8, 8'd0, INCR);
    drain();

    // Read crossing the top of memory
    wd[0] = 64'hDEAD_BEEF_CAFE_F00D;
    wr(4'd4, 32'h1FF8, 8'd0, INCR, -1, OKAY);
    drain();
    rd_d[0] = 64'hDEAD_BEEF_CAFE_F00D; rd_r[0] = OKAY;
    rd_d[1] = 64'h0;                   rd_r[1] = SLVERR;
    rd(4'd6, 32'h1FF8, 8'd1, INCR);
    drain();
    rd_r[1] = OKAY;

    // Unsupported burst: no write, SLVERR
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr(4'd7, 32'h40, 8'd0, 2'b10, -1, SLVERR);
    drain();
    rd_d[0] = 64'h11;
    rd(4'd8, 32'h40, 8'd0, INCR);
    drain();
    // w_last low on final beat, then w_last high early
    wd[0] = 64'h55; wd[1] = 64'h66;
    wr(4'd9, 32'h60, 8'd1, INCR, 1, SLVERR);
    drain();
    wr(4'd10, 32'h70, 8'd1, INCR, 0, SLVERR);
    drain();
    // Out-of-range write
    wr(4'd11, 32'h2000, 8'd0, INCR, -1, SLVERR);
    drain();
    // In-range beats of the mis-flagged burst still land in memory
    rd_d[0] = 64'h55; rd_d[1] = 64'h66;
    rd(4'd12, 32'h60, 8'd1, INCR);
    drain();
    // Unsupported read burst
    rd_d[0] = 64'h0; rd_r[0] = SLVERR;
    rd(4'd13, 32'h40, 8'd0, 2'b11);
    drain();
    rd_r[0] = OKAY;

    // Concurrent write and read under random backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wd[i] = {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
      ws[i] = 8'hFF;
    end
    rd_d[0] = 64'h11; rd_d[1] = 64'h22; rd_d[2] = 64'h33; rd_d[3] = 64'h44;
    fork
      wr(4'd14, 32'h100, 8'd7, INCR, -1, OKAY);
      rd(4'd15, 32'h40, 8'd3, INCR);
    join
    drain();
    for (int i = 0; i < 8; i++) rd_d[i] = wd[i];
    rd(4'd9, 32'h100, 8'd7, INCR);
    drain();
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during a stalled read burst
    r_hold = 1'b1;
    @(posedge clk); #1;
    ar_send(4'd3, 32'h40, 8'd3, INCR);
    @(negedge clk);
    chk("rd_stalled_valid", 128'({r_valid_o, r_data_o}), 128'({1'b1, 64'h11}));
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1 chk("rst_mid_burst", 128'({r_valid_o, r_last_o, ar_ready_o, aw_ready_o}), 128'(0));
    r_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    #1 chk("ar_ready_low_at_release", 128'(ar_ready_o), 128'(0));
    @(posedge clk); #1;
    chk("ar_ready_after_rst", 128'(ar_ready_o), 128'(1));
    rd_d[0] = 64'h22; rd_r[0] = OKAY;
    rd(4'd10, 32'h48, 8'd0, INCR);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
